data_memory_controller: RTL and testbench

- Responder end of the core's data-memory interface: accepts load/store requests with a funct3-encoded access format and serves them from an internal word-wide synchronous RAM.
- Handles byte and halfword stores as read-modify-write and applies load sign/zero extension.
- Detects misaligned or illegal-format accesses.
- Sits between the datapath's data_mem_* signals, via a valid/ready wrapper, and on-chip data storage.

---
 rtl/data_mem_pkg.sv | 77 +++++++
 rtl/data_mem_ram.sv | 26 ++
 rtl/data_memory_controller.sv | 121 ++++++++++++
 tb/tb_data_memory_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and pure helpers for the data-memory controller: access formats,
// FSM states, load extension, store lane merging and access legality.
package data_mem_pkg;

  typedef enum logic [2:0] {
    FMT_B  = 3'b000,
    FMT_H  = 3'b001,
    FMT_W  = 3'b010,
    FMT_BU = 3'b100,
    FMT_HU = 3'b101
  } mem_format_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_READ,
    STORE_READ,
    STORE_WRITE,
    RESPOND
  } mem_state_t;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  offset,
                                              input logic [2:0]  fmt);
    logic [31:0] shifted;
    shifted = word >> {offset, 3'b000};
    case (fmt)
      FMT_B:   return {{24{shifted[7]}}, shifted[7:0]};
      FMT_H:   return {{16{shifted[15]}}, shifted[15:0]};
      FMT_W:   return word;
      FMT_BU:  return {24'h0, shifted[7:0]};
      FMT_HU:  return {16'h0, shifted[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  // Replicating the data across all lanes lets one shifted mask pick the target lane(s).
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [1:0]  offset,
                                              input logic [2:0]  fmt);
    logic [31:0] mask;
    logic [31:0] lanes;
    case (fmt)
      FMT_B: begin
        mask  = 32'h0000_00FF << {offset, 3'b000};
        lanes = {4{data[7:0]}};
      end
      FMT_H: begin
        mask  = 32'h0000_FFFF << {offset, 3'b000};
        lanes = {2{data[15:0]}};
      end
      FMT_W: begin
        mask  = 32'hFFFF_FFFF;
        lanes = data;
      end
      default: begin
        mask  = 32'h0;
        lanes = 32'h0;
      end
    endcase
    return (old & ~mask) | (lanes & mask);
  endfunction

  function automatic logic access_error(input logic       write,
                                        input logic [1:0] offset,
                                        input logic [2:0] fmt);
    case (fmt)
      FMT_B:   return 1'b0;
      FMT_H:   return offset[0];
      FMT_W:   return offset != 2'b00;
      FMT_BU:  return write;
      FMT_HU:  return write | offset[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ram.sv
// Single-port synchronous word RAM with registered read data (read-before-write).
module data_mem_ram #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-3:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  localparam int Depth = 2 ** (ADDR_WIDTH - 2);

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_controller.sv
// Data-memory responder: load/store FSM over a word RAM with sub-word RMW and extension.
// Optional macro DATA_MEM_STORE_READBACK_EN returns the merged store word on resp_read_data.
module data_memory_controller
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  input  logic [2:0]  req_format,
  output logic        resp_valid,
  output logic [31:0] resp_read_data,
  output logic        resp_error
);

  mem_state_t            state_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [2:0]            fmt_q;
  logic [31:0]           oldWord_q;
  logic                  respValid_q;
  logic [31:0]           respData_q;
  logic                  respError_q;

  logic                  reqError;
  logic [ADDR_WIDTH-3:0] ramAddr;
  logic                  ramWe;
  logic [31:0]           ramRdata;
  logic [31:0]           mergedWord;
  logic                  unusedAddrBits;

  assign reqError       = access_error(req_write, req_address[1:0], req_format);
  assign unusedAddrBits = ^req_address[31:ADDR_WIDTH];

  // The read is launched from the live request in IDLE so data is ready in the next state.
  assign ramAddr    = (state_q == IDLE) ? req_address[ADDR_WIDTH-1:2] : addr_q[ADDR_WIDTH-1:2];
  assign ramWe      = (state_q == STORE_WRITE);
  assign mergedWord = store_merge(oldWord_q, data_q, addr_q[1:0], fmt_q);

  data_mem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i  (clock),
    .we_i   (ramWe),
    .addr_i (ramAddr),
    .wdata_i(mergedWord),
    .rdata_o(ramRdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      fmt_q       <= '0;
      oldWord_q   <= '0;
      respValid_q <= 1'b0;
      respData_q  <= '0;
      respError_q <= 1'b0;
    end else begin
      respValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            addr_q  <= req_address[ADDR_WIDTH-1:0];
            data_q  <= req_write_data;
            fmt_q   <= req_format;
            if (reqError) begin
              state_q     <= RESPOND;
              respValid_q <= 1'b1;
              respData_q  <= '0;
              respError_q <= 1'b1;
            end else if (!req_write) begin
              state_q <= LOAD_READ;
            end else if (req_format == FMT_W) begin
              state_q <= STORE_WRITE;
            end else begin
              state_q <= STORE_READ;
            end
          end
        end
        LOAD_READ: begin
          respData_q  <= load_extend(ramRdata, addr_q[1:0], fmt_q);
          respError_q <= 1'b0;
          respValid_q <= 1'b1;
          state_q     <= RESPOND;
        end
        STORE_READ: begin
          oldWord_q <= ramRdata;
          state_q   <= STORE_WRITE;
        end
        STORE_WRITE: begin
`ifdef DATA_MEM_STORE_READBACK_EN
          respData_q  <= write_q ? mergedWord : '0;
`else
          respData_q  <= '0;
`endif
          respError_q <= 1'b0;
          respValid_q <= 1'b1;
          state_q     <= RESPOND;
        end
        RESPOND: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = respValid_q;
  assign resp_read_data = respData_q;
  assign resp_error     = respError_q;

endmodule

// File: tb/tb_data_memory_controller.sv
// Scoreboard bench for data_memory_controller: directed requests push expected responses,
// a monitor pops and compares data, error flag and latency whenever resp_valid is seen.
module tb_data_memory_controller;

  localparam logic [2:0] FB  = 3'b000;
  localparam logic [2:0] FH  = 3'b001;
  localparam logic [2:0] FW  = 3'b010;
  localparam logic [2:0] FBU = 3'b100;
  localparam logic [2:0] FHU = 3'b101;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    int          acceptCycle;
    int          latency;
  } expect_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_address = '0;
  logic [31:0] req_write_data = '0;
  logic [2:0]  req_format = '0;
  logic        resp_valid;
  logic [31:0] resp_read_data;
  logic        resp_error;

  expect_t scoreboard[$];
  int      cycle = 0;
  int      checks = 0;
  int      errors = 0;

  data_memory_controller #(.ADDR_WIDTH(12)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_address   (req_address),
    .req_write_data(req_write_data),
    .req_format    (req_format),
    .resp_valid    (resp_valid),
    .resp_read_data(resp_read_data),
    .resp_error    (resp_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  function automatic logic [31:0] storeResp(input logic [31:0] word);
`ifdef DATA_MEM_STORE_READBACK_EN
    return word;
`else
    return 32'h0 & word;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(posedge clock) begin
    #1;
    if (resp_valid === 1'b1) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_resp_valid", 32'd1, 32'd0);
      end else begin
        expect_t e;
        e = scoreboard.pop_front();
        checkOutput({e.name, "_data"}, resp_read_data, e.data);
        checkOutput({e.name, "_error"}, {31'h0, resp_error}, {31'h0, e.err});
        checkOutput({e.name, "_latency"}, cycle - e.acceptCycle + 1, e.latency);
      end
    end
  end

  task automatic applyStimulus(input string name, input logic write, input logic [31:0] addr,
                               input logic [31:0] data, input logic [2:0] fmt,
                               input logic [31:0] expData, input logic expErr, input int expLat);
    int w;
    expect_t e;
    @(negedge clock);
    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin
      @(negedge clock);
      w++;
    end
    if (req_ready !== 1'b1) checkOutput({name, "_ready_timeout"}, {31'h0, req_ready}, 32'd1);
    req_valid      = 1'b1;
    req_write      = write;
    req_address    = addr;
    req_write_data = data;
    req_format     = fmt;
    e.name = name; e.data = expData; e.err = expErr; e.acceptCycle = cycle + 1; e.latency = expLat;
    scoreboard.push_back(e);
    @(negedge clock);
    req_valid = 1'b0;
    w = 0;
    while (scoreboard.size() != 0 && w < 10) begin
      @(posedge clock);
      #2;
      w++;
    end
    if (scoreboard.size() != 0) begin
      checkOutput({name, "_resp_timeout"}, 32'd0, 32'd1);
      void'(scoreboard.pop_front());
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    checkOutput("in_reset_ready", {31'h0, req_ready}, 32'd1);
    checkOutput("in_reset_valid", {31'h0, resp_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("reset_ready", {31'h0, req_ready}, 32'd1);
    checkOutput("reset_valid", {31'h0, resp_valid}, 32'd0);
    checkOutput("reset_data", resp_read_data, 32'h0);
    checkOutput("reset_error", {31'h0, resp_error}, 32'd0);

    applyStimulus("sw_10",  1'b1, 32'h10, 32'h8000_00F1, FW,  storeResp(32'h8000_00F1), 1'b0, 2);
    applyStimulus("lw_10",  1'b0, 32'h10, 32'h0,         FW,  32'h8000_00F1, 1'b0, 2);
    applyStimulus("lb_10",  1'b0, 32'h10, 32'h0,         FB,  32'hFFFF_FFF1, 1'b0, 2);
    applyStimulus("lbu_10", 1'b0, 32'h10, 32'h0,         FBU, 32'h0000_00F1, 1'b0, 2);
    applyStimulus("lh_12",  1'b0, 32'h12, 32'h0,         FH,  32'hFFFF_8000, 1'b0, 2);
    applyStimulus("lhu_12", 1'b0, 32'h12, 32'h0,         FHU, 32'h0000_8000, 1'b0, 2);

    applyStimulus("sw_10b", 1'b1, 32'h10, 32'h1122_3344, FW,  storeResp(32'h1122_3344), 1'b0, 2);
    applyStimulus("sb_11",  1'b1, 32'h11, 32'hFFFF_FFAB, FB,  storeResp(32'h1122_AB44), 1'b0, 3);
    applyStimulus("lw_10c", 1'b0, 32'h10, 32'h0,         FW,  32'h1122_AB44, 1'b0, 2);
    applyStimulus("lb_13",  1'b0, 32'h13, 32'h0,         FB,  32'h0000_0011, 1'b0, 2);
    applyStimulus("lb_11",  1'b0, 32'h11, 32'h0,         FB,  32'hFFFF_FFAB, 1'b0, 2);
    applyStimulus("lw_alias", 1'b0, 32'h1010, 32'h0,     FW,  32'h1122_AB44, 1'b0, 2);

    applyStimulus("lw_13_mis", 1'b0, 32'h13, 32'h0,      FW,  32'h0, 1'b1, 1);
    applyStimulus("sw_20",  1'b1, 32'h20, 32'hCAFE_BABE, FW,  storeResp(32'hCAFE_BABE), 1'b0, 2);
    applyStimulus("sh_21_mis", 1'b1, 32'h21, 32'h1111,   FH,  32'h0, 1'b1, 1);
    applyStimulus("lw_20",  1'b0, 32'h20, 32'h0,         FW,  32'hCAFE_BABE, 1'b0, 2);
    applyStimulus("fmt_011", 1'b0, 32'h20, 32'h0,        3'b011, 32'h0, 1'b1, 1);
    applyStimulus("sbu_ill", 1'b1, 32'h20, 32'h55,       FBU, 32'h0, 1'b1, 1);
    applyStimulus("sh_22",  1'b1, 32'h22, 32'h0000_BEEF, FH,  storeResp(32'hBEEF_BABE), 1'b0, 3);
    applyStimulus("lw_20b", 1'b0, 32'h20, 32'h0,         FW,  32'hBEEF_BABE, 1'b0, 2);

    // Abandon a halfword store by resetting while it sits in STORE_WRITE.
    applyStimulus("sw_30",  1'b1, 32'h30, 32'h5566_7788, FW,  storeResp(32'h5566_7788), 1'b0, 2);
    @(negedge clock);
    while (req_ready !== 1'b1) @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_address = 32'h30; req_write_data = 32'h1234; req_format = FH;
    @(negedge clock);
    req_valid = 1'b0;
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_ready", {31'h0, req_ready}, 32'd1);
    checkOutput("midrst_valid", {31'h0, resp_valid}, 32'd0);
    checkOutput("midrst_data", resp_read_data, 32'h0);
    checkOutput("midrst_error", {31'h0, resp_error}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus("lw_30",  1'b0, 32'h30, 32'h0,         FW,  32'h5566_7788, 1'b0, 2);

    repeat (3) @(negedge clock);
    checkOutput("scoreboard_empty", scoreboard.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
